// File: rtl/othello_pkg.sv
// rtl/othello_pkg.sv - shared direction/state types and board-step helpers for the move sequencer
package othello_pkg;

  localparam int DIR_IDX_W = 3;

  typedef enum logic [DIR_IDX_W-1:0] {
    DIR_U, DIR_D, DIR_L, DIR_R, DIR_UL, DIR_UR, DIR_DL, DIR_DR
  } dir_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_VSTART, ST_VWAIT, ST_FSTART, ST_FWAIT, ST_COMMIT
  } state_e;

  function automatic int addr_w_of(input int board_w);
    return $clog2(board_w * board_w);
  endfunction

  function automatic int step_w_of(input int board_w);
    return $clog2(board_w + 1) + 1;
  endfunction

  // Linear address offset of one square in the given direction on a row-major board.
  function automatic int step_of(input dir_e dir, input int board_w);
    int step;
    case (dir)
      DIR_U:   step = -board_w;
      DIR_D:   step = board_w;
      DIR_L:   step = -1;
      DIR_R:   step = 1;
      DIR_UL:  step = -(board_w + 1);
      DIR_UR:  step = -(board_w - 1);
      DIR_DL:  step = board_w - 1;
      DIR_DR:  step = board_w + 1;
      default: step = 0;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/vali_watchdog.sv
// rtl/vali_watchdog.sv - per-direction wait counter that expires after TIMEOUT cycles
module vali_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (!reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expires on the TIMEOUT-th waiting cycle, matching a validator that answers at k = TIMEOUT.
  assign o_expired = (TIMEOUT > 0) && i_enable && (r_count == LIMIT);

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - sequences validation and flip passes over all board directions for one move
module move_sequencer
  import othello_pkg::*;
#(
  parameter int BOARD_W  = 8,
  parameter int NUM_DIRS = 8,
  parameter int FLIP_EN  = 1,
  parameter int TIMEOUT  = 255,
  localparam int STEP_W  = step_w_of(BOARD_W)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     s_done,
  input  logic                     dir_status_in,
  output logic                     ld_e_addr_o,
  output logic                     ld_data_p_o,
  output logic                     ld_o,
  output logic                     start_vali,
  output logic signed [STEP_W-1:0] step_o,
  output logic                     flip_o,
  output logic                     write_to_mem_o,
  output logic                     mv_valid_o,
  output logic                     mv_done_o,
  output logic                     busy_o,
  output logic [NUM_DIRS-1:0]      dir_mask_o,
  output logic                     timeout_o
);

  localparam int DIR_W = $clog2(NUM_DIRS);
  localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(NUM_DIRS - 1);

  state_e                   r_state, w_state_next;
  logic [DIR_W-1:0]         r_dir, w_dir_next;
  logic [NUM_DIRS-1:0]      r_mask, w_mask_next, w_mask_upd;
  logic                     r_timeout, w_timeout_next;
  logic                     w_wd_clear, w_wd_en, w_wd_expired;
  logic                     w_dir_done, w_dir_status;
  logic [DIR_W:0]           w_first_set, w_next_set;
  logic signed [STEP_W-1:0] w_step;

  // Returns {found, index} of the lowest set bit at or above 'from'.
  function automatic logic [DIR_W:0] find_set(input logic [NUM_DIRS-1:0] mask, input int from);
    logic [DIR_W:0] found;
    found = '0;
    for (int i = NUM_DIRS - 1; i >= 0; i--) begin
      if (i >= from && mask[i]) found = {1'b1, DIR_W'(i)};
    end
    return found;
  endfunction

  vali_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clock     (clock),
    .reset     (reset),
    .i_clear   (w_wd_clear),
    .i_enable  (w_wd_en),
    .o_expired (w_wd_expired)
  );

  assign w_step       = STEP_W'(step_of(dir_e'(DIR_IDX_W'(r_dir)), BOARD_W));
  assign w_dir_done   = s_done || w_wd_expired;
  assign w_dir_status = s_done && dir_status_in;
  assign w_first_set  = find_set(w_mask_upd, 0);
  assign w_next_set   = find_set(r_mask, int'(r_dir) + 1);
  assign dir_mask_o   = r_mask;
  assign timeout_o    = r_timeout;

  always_comb begin
    w_mask_upd        = r_mask;
    w_mask_upd[r_dir] = w_dir_status;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_dir     <= '0;
      r_mask    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_dir     <= w_dir_next;
      r_mask    <= w_mask_next;
      r_timeout <= w_timeout_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_dir_next     = r_dir;
    w_mask_next    = r_mask;
    w_timeout_next = r_timeout;
    w_wd_clear     = 1'b0;
    w_wd_en        = 1'b0;
    ld_e_addr_o    = 1'b0;
    ld_data_p_o    = 1'b0;
    ld_o           = 1'b0;
    start_vali     = 1'b0;
    step_o         = '0;
    flip_o         = 1'b0;
    write_to_mem_o = 1'b0;
    mv_valid_o     = 1'b0;
    mv_done_o      = 1'b0;
    busy_o         = (r_state != ST_IDLE);

    case (r_state)
      ST_IDLE: begin
        if (start) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        ld_e_addr_o    = 1'b1;
        ld_data_p_o    = 1'b1;
        w_mask_next    = '0;
        w_timeout_next = 1'b0;
        w_dir_next     = '0;
        w_state_next   = ST_VSTART;
      end
      ST_VSTART: begin
        ld_o         = 1'b1;
        start_vali   = 1'b1;
        step_o       = w_step;
        w_wd_clear   = 1'b1;
        w_state_next = ST_VWAIT;
      end
      ST_VWAIT: begin
        step_o  = w_step;
        w_wd_en = 1'b1;
        if (w_dir_done) begin
          w_mask_next = w_mask_upd;
          if (!s_done) w_timeout_next = 1'b1;
          if (r_dir != LAST_DIR) begin
            w_dir_next   = r_dir + 1'b1;
            w_state_next = ST_VSTART;
          end else if (FLIP_EN != 0 && |w_mask_upd) begin
            w_dir_next   = w_first_set[DIR_W-1:0];
            w_state_next = ST_FSTART;
          end else begin
            w_state_next = ST_COMMIT;
          end
        end
      end
      ST_FSTART: begin
        ld_o         = 1'b1;
        start_vali   = 1'b1;
        step_o       = w_step;
        flip_o       = 1'b1;
        w_wd_clear   = 1'b1;
        w_state_next = ST_FWAIT;
      end
      ST_FWAIT: begin
        step_o  = w_step;
        flip_o  = 1'b1;
        w_wd_en = 1'b1;
        if (w_dir_done) begin
          if (!s_done) w_timeout_next = 1'b1;
          if (w_next_set[DIR_W]) begin
            w_dir_next   = w_next_set[DIR_W-1:0];
            w_state_next = ST_FSTART;
          end else begin
            w_state_next = ST_COMMIT;
          end
        end
      end
      ST_COMMIT: begin
        mv_done_o      = 1'b1;
        mv_valid_o     = |r_mask;
        write_to_mem_o = |r_mask;
        w_state_next   = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - randomized self-checking bench for move_sequencer against a direction-level model
module tb_move_sequencer;

  logic clock = 1'b0;
  logic reset, start, s_done, dir_status_in, sel;
  logic start0, start1;

  always #5 clock = ~clock;

  assign start0 = start && !sel;
  assign start1 = start && sel;

  logic              ld_e0, ld_d0, ld0, sv0, flip0, wr0, val0, done0, busy0, to0;
  logic signed [4:0] step0;
  logic [7:0]        mask0;
  logic              ld_e1, ld_d1, ld1, sv1, flip1, wr1, val1, done1, busy1, to1;
  logic signed [3:0] step1;
  logic [3:0]        mask1;

  move_sequencer u_dut0 (
    .clock(clock), .reset(reset), .start(start0), .s_done(s_done), .dir_status_in(dir_status_in),
    .ld_e_addr_o(ld_e0), .ld_data_p_o(ld_d0), .ld_o(ld0), .start_vali(sv0), .step_o(step0),
    .flip_o(flip0), .write_to_mem_o(wr0), .mv_valid_o(val0), .mv_done_o(done0), .busy_o(busy0),
    .dir_mask_o(mask0), .timeout_o(to0)
  );

  move_sequencer #(.BOARD_W(6), .NUM_DIRS(4), .FLIP_EN(1), .TIMEOUT(10)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .s_done(s_done), .dir_status_in(dir_status_in),
    .ld_e_addr_o(ld_e1), .ld_data_p_o(ld_d1), .ld_o(ld1), .start_vali(sv1), .step_o(step1),
    .flip_o(flip1), .write_to_mem_o(wr1), .mv_valid_o(val1), .mv_done_o(done1), .busy_o(busy1),
    .dir_mask_o(mask1), .timeout_o(to1)
  );

  logic       m_ld_e, m_ld_d, m_ld, m_sv, m_flip, m_wr, m_val, m_done, m_busy, m_to;
  int         m_step;
  logic [7:0] m_mask;

  always_comb begin
    if (sel) begin
      {m_ld_e, m_ld_d, m_ld, m_sv, m_flip} = {ld_e1, ld_d1, ld1, sv1, flip1};
      {m_wr, m_val, m_done, m_busy, m_to}  = {wr1, val1, done1, busy1, to1};
      m_step = step1;
      m_mask = {4'b0000, mask1};
    end else begin
      {m_ld_e, m_ld_d, m_ld, m_sv, m_flip} = {ld_e0, ld_d0, ld0, sv0, flip0};
      {m_wr, m_val, m_done, m_busy, m_to}  = {wr0, val0, done0, busy0, to0};
      m_step = step0;
      m_mask = mask0;
    end
  end

  // Row/column deltas in direction order U, D, L, R, UL, UR, DL, DR.
  int dr[8] = '{-1, 1, 0, 0, -1, -1, 1, 1};
  int dc[8] = '{0, 0, -1, 1, -1, 1, -1, 1};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_move(input string name, input int k, input logic [7:0] stat, input int silent,
                          input int restart_at, input bit spurious, input int abort_at);
    int w, n, tmo, t, due, cur_dir, done_t, writes, vdur, pc, exp_done;
    logic [7:0] exp_mask, got_mask;
    bit done_seen, got_val, got_wr, got_to;
    int steps_q[$];
    int flips_q[$];
    int exp_steps[$];
    int exp_flips[$];

    w   = sel ? 6 : 8;
    n   = sel ? 4 : 8;
    tmo = sel ? 10 : 255;
    exp_mask = '0;
    vdur = 0;
    for (int d = 0; d < n; d++) begin
      exp_steps.push_back(dr[d] * w + dc[d]);
      exp_flips.push_back(0);
      vdur += ((d == silent) ? tmo : k) + 1;
      if (d != silent) exp_mask[d] = stat[d];
    end
    pc = 0;
    for (int d = 0; d < n; d++) begin
      if (exp_mask[d]) begin
        exp_steps.push_back(dr[d] * w + dc[d]);
        exp_flips.push_back(1);
        pc++;
      end
    end
    exp_done = 2 + vdur + pc * (k + 1);

    @(posedge clock); #1;
    start = 1'b1;
    s_done = 1'b0;
    dir_status_in = 1'b0;
    t = 0; due = -1; cur_dir = 0; done_seen = 0; writes = 0; done_t = -1;
    got_mask = '0; got_val = 0; got_wr = 0; got_to = 0;
    while (!done_seen && t < 400 && !(abort_at >= 0 && t >= abort_at + 20)) begin
      @(posedge clock); #1;
      t++;
      start = (t == restart_at);
      reset = (t != abort_at);
      s_done = 1'b0;
      dir_status_in = 1'b0;
      if (abort_at >= 0 && t == abort_at + 1) begin
        check_eq($sformatf("%s busy after reset", name), m_busy, 0);
        check_eq($sformatf("%s mask after reset", name), m_mask, 0);
      end
      if (m_sv) begin
        steps_q.push_back(m_step);
        flips_q.push_back(m_flip);
        cur_dir = -1;
        for (int d = 0; d < n; d++) if (dr[d] * w + dc[d] == m_step) cur_dir = d;
        due = (cur_dir == silent && !m_flip) ? -1 : t + k;
        if (spurious && steps_q.size() == 1) begin
          s_done = 1'b1;
          dir_status_in = 1'b1;
        end
      end
      if (t == due) begin
        s_done = 1'b1;
        dir_status_in = (cur_dir >= 0) ? stat[cur_dir] : 1'($urandom_range(0, 1));
        due = -1;
      end
      if (m_wr) writes++;
      if (m_done) begin
        done_seen = 1;
        done_t = t;
        got_mask = m_mask;
        got_val = m_val;
        got_wr = m_wr;
        got_to = m_to;
      end
    end
    start = 1'b0;
    s_done = 1'b0;
    reset = 1'b1;

    if (abort_at >= 0) begin
      check_eq($sformatf("%s commit after abort", name), done_seen, 0);
      check_eq($sformatf("%s writes after abort", name), writes, 0);
    end else begin
      check_eq($sformatf("%s done seen", name), done_seen, 1);
      check_eq($sformatf("%s done cycle", name), done_t, exp_done);
      check_eq($sformatf("%s start count", name), steps_q.size(), exp_steps.size());
      for (int i = 0; i < exp_steps.size() && i < steps_q.size(); i++) begin
        check_eq($sformatf("%s step %0d", name, i), steps_q[i], exp_steps[i]);
        check_eq($sformatf("%s flip %0d", name, i), flips_q[i], exp_flips[i]);
      end
      check_eq($sformatf("%s mask", name), got_mask, exp_mask);
      check_eq($sformatf("%s mv_valid", name), got_val, int'(|exp_mask));
      check_eq($sformatf("%s write_to_mem", name), got_wr, int'(|exp_mask));
      check_eq($sformatf("%s write pulses", name), writes, int'(|exp_mask));
      check_eq($sformatf("%s timeout", name), got_to, int'(silent >= 0 && silent < n));
    end
  endtask

  task automatic check_idle(input string name);
    check_eq($sformatf("%s busy", name), m_busy, 0);
    check_eq($sformatf("%s mask", name), m_mask, 0);
    check_eq($sformatf("%s timeout", name), m_to, 0);
    check_eq($sformatf("%s strobes", name),
             {m_ld_e, m_ld_d, m_ld, m_sv, m_flip, m_wr, m_val, m_done}, 0);
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    s_done = 1'b0;
    dir_status_in = 1'b0;
    sel = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_idle("reset dut0");
    sel = 1'b1;
    #1;
    check_idle("reset dut1");
    sel = 1'b0;
    reset = 1'b1;

    run_move("r_dl_flip", 3, 8'b0100_1000, -1, -1, 0, -1);
    run_move("all_zero", 3, 8'h00, -1, -1, 0, -1);
    run_move("restart_spurious", 3, 8'b0100_1000, -1, 10, 1, -1);
    run_move("abort_in_flip", 3, 8'b0100_1000, -1, -1, 0, 36);
    for (int i = 0; i < 6; i++)
      run_move($sformatf("rand8_%0d", i), int'($urandom_range(1, 6)), 8'($urandom), -1, -1, 0, -1);

    sel = 1'b1;
    run_move("w6_steps", 2, 8'h00, -1, -1, 0, -1);
    run_move("w6_timeout_d", 3, 8'h0f, 1, -1, 0, -1);
    for (int i = 0; i < 6; i++)
      run_move($sformatf("rand4_%0d", i), int'($urandom_range(1, 8)), 8'($urandom & 32'hf),
               int'($urandom_range(0, 4)) - 1, -1, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
